vuvmu_ctrl_vec_cmd_dispatch: RTL and testbench

Front-end sequencer of the vector memory unit: accepts vector memory commands from the VXU command queue, forks each load into a load-address-issue command and a writeback command, and routes stores to the store issue path. Tracks in-flight load and store vectors with credit counters, caps outstanding loads, and serializes load/store direction changes so no load overtakes an older store or vice versa. Sits between the VXU command queue and the VMU address generators and load-writeback controller.

---
 rtl/vuvmu_ctrl_vec_cmd_dispatch_pkg.sv | 44 ++++
 rtl/vuvmu_ctrl_vec_cmd_dispatch_if.sv | 55 +++++
 rtl/vuvmu_ctrl_vec_cmd_dispatch_credit.sv | 39 +++
 rtl/vuvmu_ctrl_vec_cmd_dispatch.sv | 146 ++++++++++++++
 tb/tb_vuvmu_ctrl_vec_cmd_dispatch.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vuvmu_ctrl_vec_cmd_dispatch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vuvmu_pkg : shared widths, command field layout and dispatch states   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package vuvmu_pkg;

   localparam int VLEN_SZ_DEF   = 11;
   localparam int IMM_SZ_DEF    = 32;
   localparam int STRIDE_SZ_DEF = 32;

   // type field = {fp, signext, size[1:0]}
   localparam int TYPE_SZ          = 4;
   localparam int TYPE_FP_BIT      = 3;
   localparam int TYPE_SIGNEXT_BIT = 2;
   localparam int TYPE_SIZE_LSB    = 0;

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_DIR = 2'd1,
      ST_ISSUE    = 2'd2
   } state_e;

   // Command layout, LSB first: vlen, imm, stride, type, is_store
   function automatic int imm_lsb(input int vlen_sz);
      return vlen_sz;
   endfunction

   function automatic int stride_lsb(input int vlen_sz, input int imm_sz);
      return vlen_sz + imm_sz;
   endfunction

   function automatic int type_lsb(input int vlen_sz, input int imm_sz, input int stride_sz);
      return vlen_sz + imm_sz + stride_sz;
   endfunction

   function automatic int cmd_sz(input int vlen_sz, input int imm_sz, input int stride_sz);
      return 1 + TYPE_SZ + stride_sz + imm_sz + vlen_sz;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vuvmu_ctrl_vec_cmd_dispatch_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vuvmu_ctrl_vec_cmd_dispatch_if : command in, ld/wb/st issue out       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface vuvmu_ctrl_vec_cmd_dispatch_if
   import vuvmu_pkg::*;
#(
   parameter int VLEN_SZ   = VLEN_SZ_DEF,
   parameter int IMM_SZ    = IMM_SZ_DEF,
   parameter int STRIDE_SZ = STRIDE_SZ_DEF
);
   localparam int CMD_SZ = cmd_sz(VLEN_SZ, IMM_SZ, STRIDE_SZ);
   localparam int WB_SZ  = CMD_SZ - 1;

   logic [CMD_SZ-1:0] vmcmd_deq_bits;
   logic              vmcmd_deq_val;
   logic              vmcmd_deq_rdy;

   logic [WB_SZ-1:0]  issue_ld_bits;
   logic              issue_ld_val;
   logic              issue_ld_rdy;

   logic [WB_SZ-1:0]  wbcmd_enq_bits;
   logic              wbcmd_enq_val;
   logic              wbcmd_enq_rdy;

   logic [WB_SZ-1:0]  issue_st_bits;
   logic              issue_st_val;
   logic              issue_st_rdy;

   modport master (
      input  vmcmd_deq_bits, vmcmd_deq_val,
      output vmcmd_deq_rdy,
      output issue_ld_bits, issue_ld_val,
      input  issue_ld_rdy,
      output wbcmd_enq_bits, wbcmd_enq_val,
      input  wbcmd_enq_rdy,
      output issue_st_bits, issue_st_val,
      input  issue_st_rdy
   );

   modport slave (
      output vmcmd_deq_bits, vmcmd_deq_val,
      input  vmcmd_deq_rdy,
      input  issue_ld_bits, issue_ld_val,
      output issue_ld_rdy,
      input  wbcmd_enq_bits, wbcmd_enq_val,
      output wbcmd_enq_rdy,
      input  issue_st_bits, issue_st_val,
      output issue_st_rdy
   );

endinterface
`default_nettype wire

// File: rtl/vuvmu_ctrl_vec_cmd_dispatch_credit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vuvmu_credit_counter : in-flight vector count, saturating at zero     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module vuvmu_credit_counter
   import vuvmu_pkg::*;
#(
   parameter int MAX = 2
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             inc,
   input  wire logic             dec,
   output logic [CNT_W-1:0]      count,
   output logic                  at_max,
   output logic                  zero,
   output logic                  underflow
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (inc && !dec) begin
         count_reg <= count_reg + 1'b1;
      end else if (dec && !inc && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign count     = count_reg;
   assign zero      = (count_reg == '0);
   assign at_max    = (count_reg >= CNT_W'(MAX));
   assign underflow = dec && !inc && zero;

endmodule
`default_nettype wire

// File: rtl/vuvmu_ctrl_vec_cmd_dispatch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vuvmu_ctrl_vec_cmd_dispatch : forks loads to ld/wb, routes stores,    |
// | orders ld/st directions with credit counters.   Rev 1.0               |
// +-----------------------------------------------------------------------+
module vuvmu_ctrl_vec_cmd_dispatch
   import vuvmu_pkg::*;
#(
   parameter int VLEN_SZ         = VLEN_SZ_DEF,
   parameter int IMM_SZ          = IMM_SZ_DEF,
   parameter int STRIDE_SZ       = STRIDE_SZ_DEF,
   parameter int MAX_LD_INFLIGHT = 2,
   parameter int MAX_ST_INFLIGHT = 2
) (
   input  wire logic                       clk,
   input  wire logic                       reset,
   vuvmu_ctrl_vec_cmd_dispatch_if.master   cmd_bus,
   input  wire logic                       vec_ld_done,
   input  wire logic                       vec_st_done,
   output logic [CNT_W-1:0]                ld_inflight,
   output logic [CNT_W-1:0]                st_inflight,
   output logic                            busy,
   output logic                            err_underflow
);

   localparam int CMD_SZ = cmd_sz(VLEN_SZ, IMM_SZ, STRIDE_SZ);
   localparam int WB_SZ  = CMD_SZ - 1;

   state_e            state;
   state_e            next_state;
   logic [CMD_SZ-1:0] cmd_reg;
   logic              sent_ld;
   logic              sent_wb;

   logic is_store;
   logic dir_ok;
   logic deq_fire;
   logic ld_fire;
   logic wb_fire;
   logic ld_val;
   logic wb_val;
   logic st_val;
   logic ld_inc;
   logic st_inc;
   logic ld_at_max, ld_zero, ld_uf;
   logic st_at_max, st_zero, st_uf;

   assign is_store = cmd_reg[CMD_SZ-1];
   assign deq_fire = cmd_bus.vmcmd_deq_val && cmd_bus.vmcmd_deq_rdy;
   assign ld_fire  = ld_val && cmd_bus.issue_ld_rdy;
   assign wb_fire  = wb_val && cmd_bus.wbcmd_enq_rdy;

   // A direction may only proceed once the opposite direction has fully drained
   assign dir_ok = is_store ? (ld_zero && !st_at_max)
                            : (st_zero && !ld_at_max);

   always_comb begin
      next_state = state;
      ld_val     = 1'b0;
      wb_val     = 1'b0;
      st_val     = 1'b0;
      ld_inc     = 1'b0;
      st_inc     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd_bus.vmcmd_deq_val) next_state = ST_WAIT_DIR;
         end
         ST_WAIT_DIR: begin
            if (dir_ok) next_state = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (is_store) begin
               st_val = 1'b1;
               if (cmd_bus.issue_st_rdy) begin
                  st_inc     = 1'b1;
                  next_state = ST_IDLE;
               end
            end else begin
               ld_val = !sent_ld;
               wb_val = !sent_wb;
               // Each half completes once, either earlier or on this edge
               if ((sent_ld || cmd_bus.issue_ld_rdy) && (sent_wb || cmd_bus.wbcmd_enq_rdy)) begin
                  ld_inc     = 1'b1;
                  next_state = ST_IDLE;
               end
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         cmd_reg       <= '0;
         sent_ld       <= 1'b0;
         sent_wb       <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         state <= next_state;
         if (deq_fire) begin
            cmd_reg <= cmd_bus.vmcmd_deq_bits;
            sent_ld <= 1'b0;
            sent_wb <= 1'b0;
         end else begin
            if (ld_fire) sent_ld <= 1'b1;
            if (wb_fire) sent_wb <= 1'b1;
         end
         if (ld_uf || st_uf) err_underflow <= 1'b1;
      end
   end

   vuvmu_credit_counter #(.MAX(MAX_LD_INFLIGHT)) u_ld_credit (
      .clk       (clk),
      .reset     (reset),
      .inc       (ld_inc),
      .dec       (vec_ld_done),
      .count     (ld_inflight),
      .at_max    (ld_at_max),
      .zero      (ld_zero),
      .underflow (ld_uf)
   );

   vuvmu_credit_counter #(.MAX(MAX_ST_INFLIGHT)) u_st_credit (
      .clk       (clk),
      .reset     (reset),
      .inc       (st_inc),
      .dec       (vec_st_done),
      .count     (st_inflight),
      .at_max    (st_at_max),
      .zero      (st_zero),
      .underflow (st_uf)
   );

   assign cmd_bus.vmcmd_deq_rdy  = (state == ST_IDLE) && !reset;
   assign cmd_bus.issue_ld_bits  = cmd_reg[WB_SZ-1:0];
   assign cmd_bus.wbcmd_enq_bits = cmd_reg[WB_SZ-1:0];
   assign cmd_bus.issue_st_bits  = cmd_reg[WB_SZ-1:0];
   assign cmd_bus.issue_ld_val   = ld_val;
   assign cmd_bus.wbcmd_enq_val  = wb_val;
   assign cmd_bus.issue_st_val   = st_val;

   assign busy = (state != ST_IDLE) || !ld_zero || !st_zero;

endmodule
`default_nettype wire

// File: tb/tb_vuvmu_ctrl_vec_cmd_dispatch.sv
`default_nettype none
// Directed bench for vuvmu_ctrl_vec_cmd_dispatch: fork, backpressure,
// credit limits, direction ordering, underflow and mid-dispatch reset.
module tb_vuvmu_ctrl_vec_cmd_dispatch;

   localparam int CMD_SZ = 80;
   localparam int WB_SZ  = 79;

   logic clk = 1'b0;
   logic reset;
   logic vec_ld_done;
   logic vec_st_done;
   logic [2:0] ld_inflight;
   logic [2:0] st_inflight;
   logic busy;
   logic err_underflow;

   always #5 clk = ~clk;

   vuvmu_ctrl_vec_cmd_dispatch_if #(.VLEN_SZ(11), .IMM_SZ(32), .STRIDE_SZ(32)) bus ();

   vuvmu_ctrl_vec_cmd_dispatch #(
      .VLEN_SZ(11), .IMM_SZ(32), .STRIDE_SZ(32),
      .MAX_LD_INFLIGHT(2), .MAX_ST_INFLIGHT(2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_bus       (bus),
      .vec_ld_done   (vec_ld_done),
      .vec_st_done   (vec_st_done),
      .ld_inflight   (ld_inflight),
      .st_inflight   (st_inflight),
      .busy          (busy),
      .err_underflow (err_underflow)
   );

   int n_checks = 0;
   int n_errors = 0;
   int ld_hs = 0;
   int wb_hs = 0;
   int st_hs = 0;
   logic [WB_SZ-1:0] last_ld;
   logic [WB_SZ-1:0] last_wb;
   logic [WB_SZ-1:0] last_st;

   always @(posedge clk) begin
      if (bus.issue_ld_val && bus.issue_ld_rdy) begin
         ld_hs   <= ld_hs + 1;
         last_ld <= bus.issue_ld_bits;
      end
      if (bus.wbcmd_enq_val && bus.wbcmd_enq_rdy) begin
         wb_hs   <= wb_hs + 1;
         last_wb <= bus.wbcmd_enq_bits;
      end
      if (bus.issue_st_val && bus.issue_st_rdy) begin
         st_hs   <= st_hs + 1;
         last_st <= bus.issue_st_bits;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CMD_SZ-1:0] mk(input logic st, input logic [3:0] ty,
                                            input logic [31:0] stride, input logic [31:0] imm,
                                            input logic [10:0] vlen);
      return {st, ty, stride, imm, vlen};
   endfunction

   task automatic send(input logic [CMD_SZ-1:0] b);
      int waited = 0;
      while (!bus.vmcmd_deq_rdy && waited < 20) begin
         tick();
         waited++;
      end
      check("deq_rdy_wait", 128'(bus.vmcmd_deq_rdy), 128'(1));
      bus.vmcmd_deq_bits = b;
      bus.vmcmd_deq_val  = 1'b1;
      tick();
      bus.vmcmd_deq_val  = 1'b0;
   endtask

   task automatic pulse_ld_done();
      vec_ld_done = 1'b1;
      tick();
      vec_ld_done = 1'b0;
   endtask

   task automatic pulse_st_done();
      vec_st_done = 1'b1;
      tick();
      vec_st_done = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   logic [CMD_SZ-1:0] c1, c2, c3, c4, c5;
   int ld0, wb0, st0;

   initial begin
      c1 = mk(1'b0, 4'h5, 32'h0000_0010, 32'h0000_1000, 11'd6);
      c2 = mk(1'b0, 4'hA, 32'h0000_0004, 32'h0000_2000, 11'd15);
      c3 = mk(1'b1, 4'h2, 32'h0000_0008, 32'h0000_3000, 11'd3);
      c4 = mk(1'b0, 4'h3, 32'h0000_0020, 32'hDEAD_0000, 11'd1);
      c5 = mk(1'b0, 4'hE, 32'h0000_0040, 32'hBEEF_0000, 11'd2);

      reset = 1'b1;
      vec_ld_done = 1'b0;
      vec_st_done = 1'b0;
      bus.vmcmd_deq_val  = 1'b0;
      bus.vmcmd_deq_bits = '0;
      bus.issue_ld_rdy   = 1'b1;
      bus.wbcmd_enq_rdy  = 1'b1;
      bus.issue_st_rdy   = 1'b1;
      tick(); tick(); tick();

      // Reset values
      check("rst_deq_rdy", 128'(bus.vmcmd_deq_rdy), 128'(0));
      check("rst_vals", 128'({bus.issue_ld_val, bus.wbcmd_enq_val, bus.issue_st_val}), 128'(0));
      check("rst_counts", 128'({ld_inflight, st_inflight}), 128'(0));
      check("rst_busy_err", 128'({busy, err_underflow}), 128'(0));
      reset = 1'b0;
      tick();
      check("idle_deq_rdy", 128'(bus.vmcmd_deq_rdy), 128'(1));

      // Single load, all ready
      send(c1);
      check("t1_wait_busy", 128'(busy), 128'(1));
      check("t1_wait_vals", 128'({bus.issue_ld_val, bus.wbcmd_enq_val}), 128'(0));
      tick();
      check("t1_issue_vals", 128'({bus.issue_ld_val, bus.wbcmd_enq_val}), 128'(2'b11));
      check("t1_ld_bits", 128'(bus.issue_ld_bits), 128'(c1[WB_SZ-1:0]));
      check("t1_wb_bits", 128'(bus.wbcmd_enq_bits), 128'(c1[WB_SZ-1:0]));
      tick();
      check("t1_hs", 128'({ld_hs[7:0], wb_hs[7:0]}), 128'(16'h0101));
      check("t1_ld_inflight", 128'(ld_inflight), 128'(1));
      check("t1_deq_rdy", 128'(bus.vmcmd_deq_rdy), 128'(1));
      pulse_ld_done();
      check("t1_done_count", 128'(ld_inflight), 128'(0));
      check("t1_done_busy", 128'(busy), 128'(0));

      // Writeback backpressure: no duplicate load issue
      ld0 = ld_hs; wb0 = wb_hs;
      bus.wbcmd_enq_rdy = 1'b0;
      send(c2);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t2_wb_held", 128'(bus.wbcmd_enq_val), 128'(1));
         tick();
      end
      check("t2_ld_val_off", 128'(bus.issue_ld_val), 128'(0));
      check("t2_ld_once", 128'(ld_hs - ld0), 128'(1));
      check("t2_wb_none", 128'(wb_hs - wb0), 128'(0));
      check("t2_ld_count_pending", 128'(ld_inflight), 128'(0));
      bus.wbcmd_enq_rdy = 1'b1;
      tick();
      check("t2_wb_once", 128'(wb_hs - wb0), 128'(1));
      check("t2_ld_still_once", 128'(ld_hs - ld0), 128'(1));
      check("t2_wb_bits", 128'(last_wb), 128'(c2[WB_SZ-1:0]));
      check("t2_ld_inflight", 128'(ld_inflight), 128'(1));
      pulse_ld_done();

      // Load credit cap
      ld0 = ld_hs;
      send(c1); tick(); tick();
      send(c2); tick(); tick();
      check("t3_two_inflight", 128'(ld_inflight), 128'(2));
      send(c4);
      tick(); tick(); tick();
      check("t3_third_held", 128'({bus.issue_ld_val, bus.vmcmd_deq_rdy}), 128'(0));
      check("t3_held_issues", 128'(ld_hs - ld0), 128'(2));
      pulse_ld_done();
      check("t3_m1_count", 128'(ld_inflight), 128'(1));
      check("t3_m1_no_issue", 128'(bus.issue_ld_val), 128'(0));
      tick();
      check("t3_m2_issue", 128'(bus.issue_ld_val), 128'(1));
      check("t3_m2_bits", 128'(bus.issue_ld_bits), 128'(c4[WB_SZ-1:0]));
      tick();
      check("t3_count_back", 128'(ld_inflight), 128'(2));
      vec_ld_done = 1'b1;
      tick(); tick();
      vec_ld_done = 1'b0;
      check("t3_drained", 128'(ld_inflight), 128'(0));

      // Store after load waits for load drain
      st0 = st_hs;
      send(c1); tick(); tick();
      send(c3);
      tick(); tick();
      check("t4_st_held", 128'({bus.issue_st_val, st_inflight}), 128'(0));
      pulse_ld_done();
      check("t4_m1_no_st", 128'(bus.issue_st_val), 128'(0));
      tick();
      check("t4_m2_st_val", 128'(bus.issue_st_val), 128'(1));
      check("t4_st_bits", 128'(bus.issue_st_bits), 128'(c3[WB_SZ-1:0]));
      check("t4_no_ld_val", 128'({bus.issue_ld_val, bus.wbcmd_enq_val}), 128'(0));
      tick();
      check("t4_st_inflight", 128'(st_inflight), 128'(1));
      check("t4_st_hs", 128'(st_hs - st0), 128'(1));
      pulse_st_done();
      check("t4_st_drained", 128'(st_inflight), 128'(0));

      // Simultaneous inc/done, then underflow
      send(c1); tick(); tick();
      send(c2); tick();
      check("t5_issue_now", 128'(bus.issue_ld_val), 128'(1));
      pulse_ld_done();
      check("t5_inc_dec_same", 128'(ld_inflight), 128'(1));
      pulse_ld_done();
      check("t5_zero_no_err", 128'({ld_inflight, err_underflow}), 128'(0));
      pulse_ld_done();
      check("t5_uf_count", 128'(ld_inflight), 128'(0));
      check("t5_uf_err", 128'(err_underflow), 128'(1));
      tick(); tick();
      check("t5_uf_sticky", 128'(err_underflow), 128'(1));

      // Reset with writeback half pending
      bus.wbcmd_enq_rdy = 1'b0;
      send(c4); tick(); tick();
      check("t6_half_sent", 128'({bus.issue_ld_val, bus.wbcmd_enq_val}), 128'(2'b01));
      reset = 1'b1;
      tick();
      check("t6_rst_vals", 128'({bus.issue_ld_val, bus.wbcmd_enq_val, bus.issue_st_val}), 128'(0));
      check("t6_rst_counts", 128'({ld_inflight, st_inflight, err_underflow}), 128'(0));
      check("t6_rst_deq_rdy", 128'(bus.vmcmd_deq_rdy), 128'(0));
      reset = 1'b0;
      bus.wbcmd_enq_rdy = 1'b1;
      tick();
      ld0 = ld_hs; wb0 = wb_hs;
      send(c5); tick(); tick();
      check("t6_clean_hs", 128'({8'(ld_hs - ld0), 8'(wb_hs - wb0)}), 128'(16'h0101));
      check("t6_wb_bits", 128'(last_wb), 128'(c5[WB_SZ-1:0]));
      check("t6_ld_bits", 128'(last_ld), 128'(c5[WB_SZ-1:0]));
      check("t6_inflight", 128'(ld_inflight), 128'(1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
